instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Converts decoded instruction fields back into 32-bit instruction words. It is the inverse of the instruction decoder and uses the same type and subtype codes.
- Used by the test-program generator and the self-check path, so that encoded words round-trip through the decoder.
- Input side is a valid/ready field bundle. Output side is a 2-entry FIFO with a valid/ready handshake.
- Branch offsets are computed from the PC and target address, with range and alignment checks.

Parameters:
- FIFO_DEPTH, 2, output buffer entries. Must be a power of 2 and at least 2.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_instr_type  in  2  01 data, 10 memory, 11 branch, 00 invalid
- in_data_type  in  3  001 imm, 010 reg-shift-imm, 011 reg-shift-reg, 100 rrx
- in_mem_type  in  2  01 imm offset, 10 reg offset
- in_jmp_type  in  2  01 B, 10 BL
- in_cond  in  4  condition field
- in_opcode  in  4  data-processing opcode
- in_s  in  1  set-flags bit
- in_mem_ctl  in  5  P,U,B,W,L, MSB first
- in_rn  in  4  first operand register
- in_rd  in  4  destination register
- in_op2  in  12  operand2 or offset field
- in_pc  in  32  address of this instruction (branch only)
- in_target  in  32  branch target (branch only)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  FIFO head word
- err_valid  out  1  one-cycle pulse, rejected bundle
- err_code  out  2  01 bad type/subtype, 10 branch out of range, 11 misaligned target
- emit_count  out  CNT_W  count of out handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset values: FIFO empty, out_valid=0, out_instr=0, err_valid=0, err_code=0, emit_count=0. in_ready=1 after reset.
- Reset mid-operation discards all buffered words immediately.
- Packing is combinational from the bundle. The result is written into the FIFO on accept. out_valid rises the cycle after accept when the FIFO was empty (latency 1).
- in_ready = (count < FIFO_DEPTH). It is registered-count based only, with no combinational path from out_ready.
- When full with a simultaneous pop, in_ready stays 0 that cycle.
- Push and pop in the same cycle (not full) leave count unchanged and preserve order.
- Common fields: [31:28] = in_cond.
- Data-processing word:
  - [27:26]=00, [24:21]=in_opcode, [20]=in_s, [19:16]=in_rn, [15:12]=in_rd.
  - 001: [25]=1, [11:0]=in_op2.
  - 010: [25]=0, [11:0]=in_op2 with bit4 forced 0.
  - 011: [25]=0, [11:0]=in_op2 with bit7 forced 0 and bit4 forced 1.
  - 100: [25]=0, [24]=0, [11:0]=in_op2 with [7:4] forced 0110.
- Memory word:
  - [27:26]=01, [24:20]=in_mem_ctl, [19:16]=in_rn, [15:12]=in_rd, [11:0]=in_op2.
  - mem 01: [25]=0. mem 10: [25]=1, bit4 forced 0.
- Branch word: [27:26]=10. B: [25:24]=10. BL: [25:24]=11.
  - diff = in_target - in_pc - 8, in 32-bit wrapping arithmetic.
  - [23:0] = diff[25:2].
- Branch error checks, in priority order:
  - jmp type 00 or 11 → err 01.
  - in_target[1:0] != 0 → err 11.
  - diff[31:25] not all equal → err 10.
- Any other unsupported combination → err 01: instr_type 00, data type 000/101/110/111, mem type 00/11.
- An errored bundle is still consumed: it needs in_ready=1. It is not written to the FIFO. err_valid pulses in the cycle after accept, with err_code held until the next error.
- emit_count increments on each out_valid && out_ready.

Decomposition:
- Shared package instr_pkg holds:
  - type codes: INSTR_DATA=2'b01, INSTR_MEM=2'b10, INSTR_BR=2'b11
  - data subtype codes 001..100
  - mem codes, jmp codes
  - err codes
  - field bit positions
- The decoder and this block both use instr_pkg.
- One sub-module: instr_fifo, a parameterized synchronous FIFO with count, async active-low reset.
- Packing and branch checking stay in the top module as combinational logic.

Test Plan:
- Data imm: cond=E, opcode=4, s=1, rn=1, rd=2, op2=0x0FF, out_ready=1 → out_instr=0xE29120FF one cycle after accept. emit_count goes to 1.
- Branch BL: pc=0x1000, target=0x0FF8, cond=E → diff=-16, out_instr=0xEBFFFFFC. target=0x1002 → err 11 pulse, no word emitted.
- Range: pc=0, target=0x02000008 → err 10. target=0x02000004 → word accepted, offset=0x7FFFFF.
- Backpressure: out_ready=0, 3 valid bundles → first two accepted, in_ready=0 on the third. Raising out_ready drains the words in order, and the third is then accepted.
- Errors: instr_type 00, then data type 101 → err_valid pulses with code 01, count unchanged. in_ready stays 1 throughout.
- Reset mid-stream: 2 words buffered, rst_n low for one cycle → out_valid=0, emit_count=0, in_ready=1 after release.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared encoding constants for the instruction decoder and encoder:
// type/subtype codes, error codes and instruction-word field positions.
package instr_pkg;

   localparam logic [1:0] INSTR_INV  = 2'b00;
   localparam logic [1:0] INSTR_DATA = 2'b01;
   localparam logic [1:0] INSTR_MEM  = 2'b10;
   localparam logic [1:0] INSTR_BR   = 2'b11;

   localparam logic [2:0] DATA_IMM = 3'b001;
   localparam logic [2:0] DATA_RSI = 3'b010;
   localparam logic [2:0] DATA_RSR = 3'b011;
   localparam logic [2:0] DATA_RRX = 3'b100;

   localparam logic [1:0] MEM_IMM = 2'b01;
   localparam logic [1:0] MEM_REG = 2'b10;

   localparam logic [1:0] JMP_B  = 2'b01;
   localparam logic [1:0] JMP_BL = 2'b10;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_TYPE  = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_ALIGN = 2'b11;

   // Instruction class as it appears in word bits [27:26]
   localparam logic [1:0] CLS_DATA = 2'b00;
   localparam logic [1:0] CLS_MEM  = 2'b01;
   localparam logic [1:0] CLS_BR   = 2'b10;

   localparam int COND_LSB = 28;
   localparam int CLS_LSB  = 26;
   localparam int IMM_BIT  = 25;
   localparam int OPC_LSB  = 21;
   localparam int S_BIT    = 20;
   localparam int MCTL_LSB = 20;
   localparam int RN_LSB   = 16;
   localparam int RD_LSB   = 12;
   localparam int LINK_LSB = 24;

endpackage

// File: rtl/instr_encoder_fifo.sv
// Parameterized synchronous FIFO with occupancy count; the head word is
// presented directly from storage.
module instr_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_push_ok = i_push && (r_count < CW'(DEPTH));
   assign w_pop_ok  = i_pop && (r_count != {CW{1'b0}});
   assign o_data    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Storage, pointers and occupancy; pointers wrap because DEPTH is a power of 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit instruction words, checks
// branch range/alignment, and buffers the result in a small output FIFO.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_instr_type,
   input  logic [2:0]        in_data_type,
   input  logic [1:0]        in_mem_type,
   input  logic [1:0]        in_jmp_type,
   input  logic [3:0]        in_cond,
   input  logic [3:0]        in_opcode,
   input  logic              in_s,
   input  logic [4:0]        in_mem_ctl,
   input  logic [3:0]        in_rn,
   input  logic [3:0]        in_rd,
   input  logic [11:0]       in_op2,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic              err_valid,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  emit_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]    w_fifo_count;
   logic [31:0]      w_word;
   logic [1:0]       w_err;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_borrow;
   logic [29:0]      w_diff_hi;
   logic             w_in_range;
   logic             w_jmp_ok;
   logic             r_err_valid;
   logic [1:0]       r_err_code;
   logic [CNT_W-1:0] r_emit_cnt;

   assign in_ready  = (w_fifo_count < CW'(FIFO_DEPTH));
   assign out_valid = (w_fifo_count != {CW{1'b0}});
   assign w_accept  = in_valid && in_ready;
   assign w_push    = w_accept && (w_err == ERR_NONE);
   assign w_pop     = out_valid && out_ready;

   // diff[31:2] of (target - pc - 8), with the low-bit borrow folded in explicitly
   assign w_borrow   = (in_target[1:0] < in_pc[1:0]);
   assign w_diff_hi  = in_target[31:2] - in_pc[31:2] - 30'd2 - {29'd0, w_borrow};
   assign w_in_range = (w_diff_hi[29:23] == 7'h00) || (w_diff_hi[29:23] == 7'h7F);
   assign w_jmp_ok   = (in_jmp_type == JMP_B) || (in_jmp_type == JMP_BL);

   // Field packing and bundle validation
   always_comb begin
      w_word = 32'd0;
      w_err  = ERR_NONE;
      w_word[COND_LSB +: 4] = in_cond;
      case (in_instr_type)
         INSTR_DATA: begin
            w_word[CLS_LSB +: 2] = CLS_DATA;
            w_word[OPC_LSB +: 4] = in_opcode;
            w_word[S_BIT]        = in_s;
            w_word[RN_LSB +: 4]  = in_rn;
            w_word[RD_LSB +: 4]  = in_rd;
            w_word[11:0]         = in_op2;
            case (in_data_type)
               DATA_IMM: w_word[IMM_BIT] = 1'b1;
               DATA_RSI: w_word[4] = 1'b0;
               DATA_RSR: begin
                  w_word[7] = 1'b0;
                  w_word[4] = 1'b1;
               end
               DATA_RRX: begin
                  w_word[24]  = 1'b0;
                  w_word[7:4] = 4'b0110;
               end
               default: w_err = ERR_TYPE;
            endcase
         end
         INSTR_MEM: begin
            w_word[CLS_LSB +: 2]  = CLS_MEM;
            w_word[MCTL_LSB +: 5] = in_mem_ctl;
            w_word[RN_LSB +: 4]   = in_rn;
            w_word[RD_LSB +: 4]   = in_rd;
            w_word[11:0]          = in_op2;
            case (in_mem_type)
               MEM_IMM: w_word[IMM_BIT] = 1'b0;
               MEM_REG: begin
                  w_word[IMM_BIT] = 1'b1;
                  w_word[4]       = 1'b0;
               end
               default: w_err = ERR_TYPE;
            endcase
         end
         INSTR_BR: begin
            w_word[CLS_LSB +: 2]  = CLS_BR;
            w_word[LINK_LSB +: 2] = (in_jmp_type == JMP_BL) ? 2'b11 : 2'b10;
            w_word[23:0]          = w_diff_hi[23:0];
            if (!w_jmp_ok) begin
               w_err = ERR_TYPE;
            end else if (in_target[1:0] != 2'b00) begin
               w_err = ERR_ALIGN;
            end else if (!w_in_range) begin
               w_err = ERR_RANGE;
            end else begin
               w_err = ERR_NONE;
            end
         end
         default: w_err = ERR_TYPE;
      endcase
   end

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (w_pop),
      .o_data  (out_instr),
      .o_count (w_fifo_count)
   );

   // Error pulse, sticky error code and emitted-word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_valid <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_emit_cnt  <= {CNT_W{1'b0}};
      end else begin
         r_err_valid <= w_accept && (w_err != ERR_NONE);
         if (w_accept && (w_err != ERR_NONE)) begin
            r_err_code <= w_err;
         end
         if (w_pop) begin
            r_emit_cnt <= r_emit_cnt + CNT_W'(1);
         end
      end
   end

   assign err_valid  = r_err_valid;
   assign err_code   = r_err_code;
   assign emit_count = r_emit_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_instr_type;
   logic [2:0]  in_data_type;
   logic [1:0]  in_mem_type;
   logic [1:0]  in_jmp_type;
   logic [3:0]  in_cond;
   logic [3:0]  in_opcode;
   logic        in_s;
   logic [4:0]  in_mem_ctl;
   logic [3:0]  in_rn;
   logic [3:0]  in_rd;
   logic [11:0] in_op2;
   logic [31:0] in_pc;
   logic [31:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        err_valid;
   logic [1:0]  err_code;
   logic [15:0] emit_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_emit = 0;

   instr_encoder #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr_type(in_instr_type), .in_data_type(in_data_type),
      .in_mem_type(in_mem_type), .in_jmp_type(in_jmp_type), .in_cond(in_cond),
      .in_opcode(in_opcode), .in_s(in_s), .in_mem_ctl(in_mem_ctl),
      .in_rn(in_rn), .in_rd(in_rd), .in_op2(in_op2), .in_pc(in_pc),
      .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .err_valid(err_valid), .err_code(err_code),
      .emit_count(emit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fields;
      in_instr_type = 2'b00; in_data_type = 3'b000; in_mem_type = 2'b00;
      in_jmp_type = 2'b00; in_cond = 4'h0; in_opcode = 4'h0; in_s = 1'b0;
      in_mem_ctl = 5'd0; in_rn = 4'h0; in_rd = 4'h0; in_op2 = 12'h000;
      in_pc = 32'd0; in_target = 32'd0;
   endtask

   task automatic set_data(input logic [2:0] dt, input logic [3:0] opc, input logic s,
                           input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] op2);
      clear_fields();
      in_instr_type = 2'b01; in_data_type = dt; in_cond = 4'hE;
      in_opcode = opc; in_s = s; in_rn = rn; in_rd = rd; in_op2 = op2;
   endtask

   task automatic set_mem(input logic [1:0] mt, input logic [4:0] ctl, input logic [11:0] op2);
      clear_fields();
      in_instr_type = 2'b10; in_mem_type = mt; in_cond = 4'hE;
      in_mem_ctl = ctl; in_rn = 4'h1; in_rd = 4'h2; in_op2 = op2;
   endtask

   task automatic set_br(input logic [1:0] jt, input logic [31:0] pc, input logic [31:0] tgt);
      clear_fields();
      in_instr_type = 2'b11; in_jmp_type = jt; in_cond = 4'hE;
      in_pc = pc; in_target = tgt;
   endtask

   // Present the current bundle for one accept cycle, then expect the word at the head
   task automatic send_word(input string tag, input logic [31:0] exp_word);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_word"}, out_instr, exp_word);
      check({tag, "_noerr"}, {31'd0, err_valid}, 32'd0);
      tick();
      exp_emit++;
      check({tag, "_emit"}, {16'd0, emit_count}, exp_emit);
   endtask

   // Present the current bundle and expect it to be rejected with the given code
   task automatic send_err(input string tag, input logic [1:0] exp_code);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_errv"}, {31'd0, err_valid}, 32'd1);
      check({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
      check({tag, "_nowrite"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      check({tag, "_pulse"}, {31'd0, err_valid}, 32'd0);
      check({tag, "_hold"}, {30'd0, err_code}, {30'd0, exp_code});
      check({tag, "_emit"}, {16'd0, emit_count}, exp_emit);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      clear_fields();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_err_valid", {31'd0, err_valid}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_emit", {16'd0, emit_count}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      out_ready = 1'b1;
      set_data(3'b001, 4'h4, 1'b1, 4'h1, 4'h2, 12'h0FF); send_word("data_imm", 32'hE29120FF);
      set_data(3'b010, 4'hD, 1'b0, 4'h0, 4'h3, 12'hFFF); send_word("data_rsi", 32'hE1A03FEF);
      set_data(3'b011, 4'hD, 1'b0, 4'h0, 4'h3, 12'hFFF); send_word("data_rsr", 32'hE1A03F7F);
      set_data(3'b100, 4'hD, 1'b0, 4'h0, 4'h3, 12'hFFF); send_word("data_rrx", 32'hE0A03F6F);
      set_mem(2'b01, 5'b11001, 12'h004); send_word("mem_imm", 32'hE5912004);
      set_mem(2'b10, 5'b11001, 12'h01F); send_word("mem_reg", 32'hE791200F);
      set_br(2'b10, 32'h0000_1000, 32'h0000_0FF8); send_word("br_bl", 32'hEBFFFFFC);
      set_br(2'b10, 32'h0000_1000, 32'h0000_1002); send_err("br_align", 2'b11);
      set_br(2'b01, 32'h0000_0000, 32'h0200_0008); send_err("br_range", 2'b10);
      set_br(2'b01, 32'h0000_0000, 32'h0200_0004); send_word("br_edge", 32'hEA7FFFFF);
      set_br(2'b11, 32'h0000_1000, 32'h0000_1002); send_err("br_jmp11", 2'b01);

      clear_fields(); send_err("type00", 2'b01);
      set_data(3'b101, 4'h4, 1'b1, 4'h1, 4'h2, 12'h0FF); send_err("dtype101", 2'b01);
      set_mem(2'b11, 5'b11001, 12'h004); send_err("mtype11", 2'b01);

      // Backpressure: two words fill the FIFO, the third waits for space
      out_ready = 1'b0;
      set_data(3'b001, 4'h4, 1'b1, 4'h1, 4'h2, 12'h001); in_valid = 1'b1; tick();
      set_data(3'b001, 4'h4, 1'b1, 4'h1, 4'h2, 12'h002); tick();
      set_data(3'b001, 4'h4, 1'b1, 4'h1, 4'h2, 12'h003);
      check("bp_full_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_still_full", {31'd0, in_ready}, 32'd0);
      check("bp_head_a", out_instr, 32'hE2912001);
      out_ready = 1'b1;
      tick();
      exp_emit++;
      check("bp_head_b", out_instr, 32'hE2912002);
      check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
      tick();
      exp_emit++;
      in_valid = 1'b0;
      check("bp_head_c", out_instr, 32'hE2912003);
      check("bp_valid_c", {31'd0, out_valid}, 32'd1);
      tick();
      exp_emit++;
      check("bp_drained", {31'd0, out_valid}, 32'd0);
      check("bp_emit", {16'd0, emit_count}, exp_emit);

      // Reset mid-stream with two words buffered
      out_ready = 1'b0;
      set_data(3'b001, 4'h4, 1'b1, 4'h1, 4'h2, 12'h011); in_valid = 1'b1; tick();
      set_data(3'b001, 4'h4, 1'b1, 4'h1, 4'h2, 12'h012); tick();
      in_valid = 1'b0;
      check("mid_full", {31'd0, in_ready}, 32'd0);
      check("mid_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #2;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_emit", {16'd0, emit_count}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_post_ready", {31'd0, in_ready}, 32'd1);
      check("mid_post_valid", {31'd0, out_valid}, 32'd0);
      check("mid_post_instr", out_instr, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
